// File: rtl/rf_wb_seq.sv
// Write-back sequencer: buffers write-back requests and expands each into the register
// file's read-then-merge-write cycle pairs (high half first for full-word writes).
module rf_wb_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDR_W-1:0]             req_reg,
   input  logic [DATA_W-1:0]             req_data,
   input  logic [1:0]                    req_mode,
   output logic                          rf_we,
   output logic [ADDR_W-1:0]             rf_write_reg,
   output logic [DATA_W-1:0]             rf_data_in,
   output logic                          rf_hl,
   output logic                          wb_busy,
   output logic                          wb_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] MODE_DROP = 2'b00;
   localparam logic [1:0] MODE_LO   = 2'b01;
   localparam logic [1:0] MODE_HI   = 2'b10;
   localparam logic [1:0] MODE_FULL = 2'b11;

   typedef enum logic [2:0] {IDLE, RD_H, WR_H, RD_L, WR_L} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] rg;
      logic [DATA_W-1:0] data;
      logic [1:0]        mode;
   } wb_req_t;

   wb_req_t          fifo_mem [FIFO_DEPTH];
   wb_req_t          head;
   wb_req_t          work;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   state_t           state;
   state_t           state_nx;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             load;
   logic             finish;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign head      = fifo_mem[rd_ptr];

   // Storage needs no reset: contents are only read when count says they are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {req_reg, req_data, req_mode};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= IDLE;
         work   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         state <= state_nx;
         if (load) work <= head;
      end
   end

   // A request finishes on WR_L, or on WR_H when only the high half is written.
   assign finish = (state == WR_L) || ((state == WR_H) && (work.mode != MODE_FULL));

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE:    state_nx = IDLE;
         RD_H:    state_nx = WR_H;
         WR_H:    state_nx = (work.mode == MODE_FULL) ? RD_L : IDLE;
         RD_L:    state_nx = WR_L;
         WR_L:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // Pop from IDLE or on the finishing write so back-to-back requests see no bubble.
      if (((state == IDLE) || finish) && !empty) begin
         pop = 1'b1;
         case (head.mode)
            MODE_FULL, MODE_HI: begin
               state_nx = RD_H;
               load     = 1'b1;
            end
            MODE_LO: begin
               state_nx = RD_L;
               load     = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      rf_we        = 1'b0;
      rf_hl        = 1'b0;
      rf_write_reg = '0;
      rf_data_in   = '0;
      case (state)
         RD_H: begin
            rf_hl        = 1'b1;
            rf_write_reg = work.rg;
         end
         WR_H: begin
            rf_we        = 1'b1;
            rf_hl        = 1'b1;
            rf_write_reg = work.rg;
            rf_data_in   = work.data;
         end
         RD_L: rf_write_reg = work.rg;
         WR_L: begin
            rf_we        = 1'b1;
            rf_write_reg = work.rg;
            rf_data_in   = work.data;
         end
         default: ;
      endcase
   end

   assign wb_done    = finish;
   assign wb_busy    = (state != IDLE) || !empty;
   assign fifo_count = count;

endmodule

// File: tb/tb_rf_wb_seq.sv
// Bench for rf_wb_seq: table of single requests plus hand-written multi-request sequences,
// checked against a behavioural register-file model that merges on each write.
module tb_rf_wb_seq;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_reg;
   logic [31:0] req_data;
   logic [1:0]  req_mode;
   logic        rf_we;
   logic [3:0]  rf_write_reg;
   logic [31:0] rf_data_in;
   logic        rf_hl;
   logic        wb_busy;
   logic        wb_done;
   logic [2:0]  fifo_count;

   rf_wb_seq #(.FIFO_DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_reg(req_reg), .req_data(req_data), .req_mode(req_mode),
      .rf_we(rf_we), .rf_write_reg(rf_write_reg), .rf_data_in(rf_data_in),
      .rf_hl(rf_hl), .wb_busy(wb_busy), .wb_done(wb_done), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: read cycles latch the old value, write cycles merge one half into it.
   logic [31:0] rf_m [16];
   logic [31:0] old_m;
   logic        pre_en;
   logic [3:0]  pre_reg;
   logic [31:0] pre_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) rf_m[i] <= '0;
         old_m <= '0;
      end else if (pre_en) begin
         rf_m[pre_reg] <= pre_val;
      end else if (rf_we) begin
         rf_m[rf_write_reg] <= rf_hl ? {rf_data_in[31:16], old_m[15:0]}
                                     : {old_m[31:16], rf_data_in[15:0]};
      end else begin
         old_m <= rf_m[rf_write_reg];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] r, input logic [31:0] v);
      pre_en  = 1'b1;
      pre_reg = r;
      pre_val = v;
      tick();
      pre_en  = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  reg_i;
      logic [31:0] pre;
      logic [31:0] data;
      logic [1:0]  mode;
      int          ncyc;
      logic [3:0]  we_s;
      logic [3:0]  hl_s;
      logic [3:0]  done_s;
      logic [31:0] fin;
   } vec_t;

   vec_t vt [6];

   task automatic apply_vec(input int i);
      preload(vt[i].reg_i, vt[i].pre);
      req_valid = 1'b1;
      req_reg   = vt[i].reg_i;
      req_data  = vt[i].data;
      req_mode  = vt[i].mode;
      tick();
      req_valid = 1'b0;
      chk($sformatf("v%0d count_after_push", i), 32'(fifo_count), 32'd1);
      chk($sformatf("v%0d busy_after_push", i), 32'(wb_busy), 32'd1);
      for (int c = 0; c < vt[i].ncyc; c++) begin
         tick();
         chk($sformatf("v%0d c%0d we", i, c), 32'(rf_we), 32'(vt[i].we_s[c]));
         chk($sformatf("v%0d c%0d hl", i, c), 32'(rf_hl), 32'(vt[i].hl_s[c]));
         chk($sformatf("v%0d c%0d done", i, c), 32'(wb_done), 32'(vt[i].done_s[c]));
         chk($sformatf("v%0d c%0d reg", i, c), 32'(rf_write_reg), 32'(vt[i].reg_i));
         if (vt[i].we_s[c]) chk($sformatf("v%0d c%0d data", i, c), rf_data_in, vt[i].data);
      end
      tick();
      chk($sformatf("v%0d idle_we", i), 32'(rf_we), 32'd0);
      chk($sformatf("v%0d idle_busy", i), 32'(wb_busy), 32'd0);
      chk($sformatf("v%0d idle_reg", i), 32'(rf_write_reg), 32'd0);
      chk($sformatf("v%0d idle_data", i), rf_data_in, 32'd0);
      chk($sformatf("v%0d idle_count", i), 32'(fifo_count), 32'd0);
      chk($sformatf("v%0d rf_final", i), rf_m[vt[i].reg_i], vt[i].fin);
   endtask

   // Stream driver: holds req_valid, advances on each accepted request, gathers statistics.
   logic [3:0]  s_reg  [16];
   logic [31:0] s_data [16];
   logic [1:0]  s_mode [16];
   logic [3:0]  done_reg [16];
   int we_cnt, done_cnt, max_cnt, ready_bad, first_c, last_c;
   bit timed_out;

   task automatic run_stream(input int n, input int n_done);
      int idx;
      int cyc;
      bit fire;
      idx = 0; cyc = 0;
      we_cnt = 0; done_cnt = 0; max_cnt = 0; ready_bad = 0; first_c = -1; last_c = -1;
      req_valid = 1'b1;
      req_reg = s_reg[0]; req_data = s_data[0]; req_mode = s_mode[0];
      while (cyc < 300 && !(idx == n && done_cnt == n_done && !wb_busy)) begin
         @(negedge clk);
         fire = req_valid && req_ready;
         if (rf_we) we_cnt++;
         if (rf_hl && first_c < 0) first_c = cyc;
         if (wb_done) begin
            if (done_cnt < 16) done_reg[done_cnt] = rf_write_reg;
            done_cnt++;
            last_c = cyc;
         end
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (fifo_count == 3'd4 && req_ready) ready_bad++;
         @(posedge clk);
         #1;
         cyc++;
         if (fire) begin
            idx++;
            if (idx < n) begin
               req_reg = s_reg[idx]; req_data = s_data[idx]; req_mode = s_mode[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      timed_out = (cyc >= 300);
   endtask

   initial begin
      vt[0] = '{4'd3,  32'h0000_0000, 32'hAAAA_1234, 2'b01, 2, 4'b0010, 4'b0000, 4'b0010, 32'h0000_1234};
      vt[1] = '{4'd5,  32'h0000_0000, 32'hDEAD_BEEF, 2'b11, 4, 4'b1010, 4'b0011, 4'b1000, 32'hDEAD_BEEF};
      vt[2] = '{4'd7,  32'h1234_5678, 32'hABCD_9999, 2'b10, 2, 4'b0010, 4'b0011, 4'b0010, 32'hABCD_5678};
      vt[3] = '{4'd9,  32'hCAFE_F00D, 32'h0000_0000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000, 32'hCAFE_F00D};
      vt[4] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01, 2, 4'b0010, 4'b0000, 4'b0010, 32'hFFFF_0000};
      vt[5] = '{4'd0,  32'h5555_5555, 32'h0123_4567, 2'b11, 4, 4'b1010, 4'b0011, 4'b1000, 32'h0123_4567};

      reset = 1'b1; req_valid = 1'b0; req_reg = '0; req_data = '0; req_mode = '0;
      pre_en = 1'b0; pre_reg = '0; pre_val = '0;
      #12;
      chk("rst we", 32'(rf_we), 32'd0);
      chk("rst reg", 32'(rf_write_reg), 32'd0);
      chk("rst data", rf_data_in, 32'd0);
      chk("rst hl", 32'(rf_hl), 32'd0);
      chk("rst busy", 32'(wb_busy), 32'd0);
      chk("rst done", 32'(wb_done), 32'd0);
      chk("rst count", 32'(fifo_count), 32'd0);
      chk("rst ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) apply_vec(i);

      // Merge chain: high half then low half to the same register, no IDLE between them.
      preload(4'd2, 32'h5A5A_5A5A);
      req_valid = 1'b1; req_reg = 4'd2; req_data = 32'h1111_0000; req_mode = 2'b10;
      tick();
      req_data = 32'h0000_2222; req_mode = 2'b01;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         chk($sformatf("chain c%0d we", c), 32'(rf_we), 32'(c % 2));
         chk($sformatf("chain c%0d hl", c), 32'(rf_hl), (c < 2) ? 32'd1 : 32'd0);
         chk($sformatf("chain c%0d done", c), 32'(wb_done), 32'(c % 2));
         chk($sformatf("chain c%0d reg", c), 32'(rf_write_reg), 32'd2);
      end
      tick();
      chk("chain rf", rf_m[2], 32'h1111_2222);
      chk("chain busy", 32'(wb_busy), 32'd0);

      // FIFO full: six full-word requests with req_valid held.
      for (int k = 0; k < 6; k++) begin
         s_reg[k]  = 4'(k + 1);
         s_data[k] = 32'hC0DE_0000 + 32'(k) * 32'h0101_0101;
         s_mode[k] = 2'b11;
      end
      run_stream(6, 6);
      chk("full timeout", 32'(timed_out), 32'd0);
      chk("full max_count", 32'(max_cnt), 32'd4);
      chk("full ready_at_4", 32'(ready_bad), 32'd0);
      chk("full we_cycles", 32'(we_cnt), 32'd12);
      chk("full done_pulses", 32'(done_cnt), 32'd6);
      chk("full rf_cycles", 32'(last_c - first_c + 1), 32'd24);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("full order%0d", k), 32'(done_reg[k]), 32'(k + 1));
         chk($sformatf("full rf%0d", k + 1), rf_m[k + 1], s_data[k]);
      end

      // Drop/wrap: alternate mode 00 and 01 across ten requests.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) begin
            s_reg[k] = 4'(k / 2 + 1); s_data[k] = 32'hFFFF_FFFF; s_mode[k] = 2'b00;
         end else begin
            s_reg[k] = 4'(8 + k / 2); s_data[k] = 32'h0000_1000 + 32'(k); s_mode[k] = 2'b01;
         end
      end
      run_stream(10, 5);
      chk("drop timeout", 32'(timed_out), 32'd0);
      chk("drop we_cycles", 32'(we_cnt), 32'd5);
      chk("drop done_pulses", 32'(done_cnt), 32'd5);
      chk("drop count_end", 32'(fifo_count), 32'd0);
      chk("drop untouched", rf_m[1], 32'd0);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("drop order%0d", j), 32'(done_reg[j]), 32'(8 + j));
         chk($sformatf("drop rf%0d", 8 + j), rf_m[8 + j], 32'h0000_1000 + 32'(2 * j + 1));
      end

      // Reset during WR_H of a full-word request with another request queued.
      req_valid = 1'b1; req_reg = 4'd4; req_data = 32'h8765_4321; req_mode = 2'b11;
      tick();
      req_reg = 4'd6; req_data = 32'h0000_7777; req_mode = 2'b01;
      tick();
      req_valid = 1'b0;
      tick();
      chk("midrst in WR_H we", 32'(rf_we), 32'd1);
      chk("midrst in WR_H hl", 32'(rf_hl), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst we", 32'(rf_we), 32'd0);
      chk("midrst reg", 32'(rf_write_reg), 32'd0);
      chk("midrst data", rf_data_in, 32'd0);
      chk("midrst hl", 32'(rf_hl), 32'd0);
      chk("midrst busy", 32'(wb_busy), 32'd0);
      chk("midrst count", 32'(fifo_count), 32'd0);
      chk("midrst ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      tick();
      apply_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
